// File: rtl/btn_pkg.sv
// Shared constants for the push-button input-conditioning path.
// Button indices and debounce lengths for hardware and benches.
package btn_pkg;

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;

  localparam int NUM_BTN_DEF = 2;
  localparam int SYNC_STAGES_DEF = 2;

  // 10 ms at 100 MHz on the board; short count for simulation
  localparam int DEBOUNCE_CYCLES_HW = 1_000_000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, stability counter,
// debounced level and registered press/release pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_err
    $error("btn_debounce_ch: SYNC_STAGES and DEBOUNCE_CYCLES must be >= 2");
  end

  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_STAGES-1:0] sync_q;

  logic          s;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic          release_q;
  logic          release_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Any sample matching the level restarts the count from zero
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d   = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces NUM_BTN asynchronous push-buttons into the clk domain.
// Each channel is fully independent.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
  input  logic               clk,
  input  logic               CPU_RESETN,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i    (clk),
      .rst_ni   (CPU_RESETN),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule
